// File: rtl/diffuse_sched_if.sv
// diffuse_sched_if: requester, shade_diffuse and response signals of the diffuse scheduler
interface diffuse_sched_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0]   req_vld;
  logic [NUM_REQ*8-1:0] req_ray_id;
  logic [NUM_REQ-1:0]   req_rdy;
  logic                 sd_op_vld;
  logic [15:0]          sd_r1;
  logic [15:0]          sd_r2;
  logic                 sd_result_vld;
  logic [95:0]          sd_result;
  logic [NUM_REQ-1:0]   rsp_vld;
  logic [7:0]           rsp_ray_id;
  logic [95:0]          rsp_dir;
  logic                 align_err;
  modport slave (
    input  req_vld, req_ray_id, sd_result_vld, sd_result,
    output req_rdy, sd_op_vld, sd_r1, sd_r2, rsp_vld, rsp_ray_id, rsp_dir, align_err
  );
  modport master (
    output req_vld, req_ray_id, sd_result_vld, sd_result,
    input  req_rdy, sd_op_vld, sd_r1, sd_r2, rsp_vld, rsp_ray_id, rsp_dir, align_err
  );
endinterface

// File: rtl/diffuse_sched.sv
// diffuse_sched: round-robin sharing of one fixed-latency shade_diffuse pipe with LFSR operands
module diffuse_sched #(
  parameter int          NUM_REQ      = 4,
  parameter int          PIPE_LATENCY = 36,
  parameter int          MAX_OUT      = 8,
  parameter logic [31:0] LFSR_SEED    = 32'h1ACE_B00C
) (
  input logic           clk,
  input logic           rst,
  diffuse_sched_if.slave bus
);
  localparam int          IW   = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int          DW   = $clog2(PIPE_LATENCY + 2);
  localparam logic [31:0] SEED = LFSR_SEED == 32'd0 ? 32'd1 : LFSR_SEED;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
    logic [7:0]    id;
  } tag_t;

  logic [DW-1:0]      r_drain;
  logic [IW-1:0]      r_rr;
  logic [7:0]         r_cnt [NUM_REQ];
  logic [31:0]        r_lfsr;
  logic [15:0]        r_r1, r_r2;
  tag_t               r_issue;
  tag_t               r_pipe [PIPE_LATENCY];
  logic [NUM_REQ-1:0] r_ret, r_rsp;
  logic [7:0]         r_rsp_id;
  logic [95:0]        r_dir;
  logic               r_err;

  logic               w_drained;
  logic [NUM_REQ-1:0] w_elig, w_rdy;
  logic               w_gnt_vld;
  logic [IW-1:0]      w_gnt_idx;
  logic [7:0]         w_gnt_id;
  tag_t               w_tag;
  logic               w_hit;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v >= NUM_REQ ? v - NUM_REQ : v);
  endfunction

  // -1.0 is excluded so both operands stay strictly inside (-1.0, 1.0)
  function automatic logic [15:0] opnd(input logic [13:0] v);
    return {{2{v[13]}}, v} == 16'hE000 ? 16'hE001 : {{2{v[13]}}, v};
  endfunction

  assign w_drained = r_drain == '0;
  assign w_tag     = r_pipe[PIPE_LATENCY-1];
  assign w_hit     = w_tag.vld && bus.sd_result_vld && w_drained;

  for (genvar g = 0; g < NUM_REQ; g++)
    assign w_elig[g] = bus.req_vld[g] && r_cnt[g] < 8'(MAX_OUT) && w_drained;

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (w_elig[wrap(int'(r_rr) + k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = wrap(int'(r_rr) + k);
      end
  end

  assign w_rdy    = w_gnt_vld ? NUM_REQ'(1) << w_gnt_idx : '0;
  assign w_gnt_id = bus.req_ray_id[{w_gnt_idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain  <= DW'(PIPE_LATENCY + 1);
      r_rr     <= '0;
      r_lfsr   <= SEED;
      r_r1     <= '0;
      r_r2     <= '0;
      r_issue  <= '0;
      r_ret    <= '0;
      r_rsp    <= '0;
      r_rsp_id <= '0;
      r_dir    <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
      for (int k = 0; k < PIPE_LATENCY; k++) r_pipe[k] <= '0;
    end else begin
      r_drain <= w_drained ? r_drain : r_drain - 1'b1;
      if (w_gnt_vld) begin
        r_rr   <= wrap(int'(w_gnt_idx) + 1);
        r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
        r_r1   <= opnd(r_lfsr[13:0]);
        r_r2   <= opnd(r_lfsr[29:16]);
      end
      r_issue   <= {w_gnt_vld, w_gnt_idx, w_gnt_id};
      r_pipe[0] <= r_issue;
      for (int k = 1; k < PIPE_LATENCY; k++) r_pipe[k] <= r_pipe[k-1];
      // retire on every emerging tag so a lost result still frees its slot
      r_ret <= w_tag.vld ? NUM_REQ'(1) << w_tag.idx : '0;
      r_rsp <= w_hit ? NUM_REQ'(1) << w_tag.idx : '0;
      if (w_hit) begin
        r_rsp_id <= w_tag.id;
        r_dir    <= bus.sd_result;
      end
      if (w_drained && w_tag.vld != bus.sd_result_vld) r_err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        r_cnt[i] <= r_cnt[i] + {7'd0, w_rdy[i]} - {7'd0, r_ret[i] && r_cnt[i] != 8'd0};
    end
  end

  assign bus.req_rdy    = w_rdy;
  assign bus.sd_op_vld  = r_issue.vld;
  assign bus.sd_r1      = r_r1;
  assign bus.sd_r2      = r_r2;
  assign bus.rsp_vld    = r_rsp;
  assign bus.rsp_ray_id = r_rsp_id;
  assign bus.rsp_dir    = r_dir;
  assign bus.align_err  = r_err;
endmodule

// File: tb/tb_diffuse_sched.sv
// tb_diffuse_sched: random traffic on a main instance against a queue model, plus
// directed outstanding-limit, forced-operand, misalignment and mid-operation reset checks
module tb_diffuse_sched;
  localparam int N = 4, PL = 36;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  diffuse_sched_if #(.NUM_REQ(N)) ia ();
  diffuse_sched_if #(.NUM_REQ(N)) ib ();
  diffuse_sched_if #(.NUM_REQ(N)) ic ();

  diffuse_sched #(.NUM_REQ(N), .PIPE_LATENCY(PL), .MAX_OUT(8), .LFSR_SEED(32'd1))
    ua (.clk(clk), .rst(rst), .bus(ia));
  diffuse_sched #(.NUM_REQ(N), .PIPE_LATENCY(PL), .MAX_OUT(3), .LFSR_SEED(32'h0000_2000))
    ub (.clk(clk), .rst(rst), .bus(ib));
  diffuse_sched #(.NUM_REQ(N), .PIPE_LATENCY(PL), .MAX_OUT(8))
    uc (.clk(clk), .rst(rst), .bus(ic));

  // stub pipelines never reset, like the real shade_diffuse; uc's stub is one cycle too slow
  logic [96:0] sa [PL];
  logic [96:0] sb [PL];
  logic [96:0] sc [PL+1];
  logic [7:0]  a_id;

  function automatic logic [7:0] gid(input logic [N-1:0] r, input logic [8*N-1:0] d);
    for (int i = 0; i < N; i++) if (r[i]) return d[8*i +: 8];
    return 8'd0;
  endfunction

  initial begin
    a_id = 8'd0;
    for (int k = 0; k < PL; k++) begin sa[k] = '0; sb[k] = '0; end
    for (int k = 0; k <= PL; k++) sc[k] = '0;
  end

  always @(posedge clk) begin
    a_id  <= gid(ia.req_rdy, ia.req_ray_id);
    sa[0] <= {ia.sd_op_vld, ia.sd_r2, ia.sd_r1, 56'h0, a_id};
    sb[0] <= {ib.sd_op_vld, 96'h0};
    sc[0] <= {ic.sd_op_vld, 96'h0};
    for (int k = 1; k < PL; k++) begin sa[k] <= sa[k-1]; sb[k] <= sb[k-1]; end
    for (int k = 1; k <= PL; k++) sc[k] <= sc[k-1];
  end

  assign ia.sd_result_vld = sa[PL-1][96];
  assign ia.sd_result     = sa[PL-1][95:0];
  assign ib.sd_result_vld = sb[PL-1][96];
  assign ib.sd_result     = sb[PL-1][95:0];
  assign ic.sd_result_vld = sc[PL][96];
  assign ic.sd_result     = sc[PL][95:0];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         g;
    int         idx;
    logic [7:0] id;
    logic [15:0] r1;
    logic [15:0] r2;
  } ent_t;

  ent_t        q[$];
  int          rr;
  logic [31:0] lf;
  logic        op_e;
  logic [15:0] r1e, r2e;
  logic [N-1:0] pend;
  logic [7:0]  ids [N];

  function automatic logic [15:0] opm(input logic [31:0] s, input int lo);
    int v;
    v = int'((s >> lo) & 32'h3FFF);
    if (v >= 8192) v -= 16384;
    if (v == -8192) v = -8191;
    return 16'(v);
  endfunction

  function automatic logic [31:0] lnext(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int outst(input int i);
    int n = 0;
    foreach (q[k]) if (q[k].idx == i) n++;
    return n;
  endfunction

  task automatic do_reset(input int n);
    q.delete();
    rr   = 0;
    lf   = 32'd1;
    op_e = 1'b0;
    r1e  = '0;
    r2e  = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_a", 128'({ia.req_rdy, ia.sd_op_vld, ia.sd_r1, ia.sd_r2, ia.rsp_vld, ia.rsp_ray_id, ia.align_err}), 128'(0));
      chk("rst_a_dir", 128'(ia.rsp_dir), 128'(0));
      chk("rst_b", 128'({ib.req_rdy, ib.sd_op_vld, ib.sd_r1, ib.sd_r2}), 128'(0));
      chk("rst_c_err", 128'(ic.align_err), 128'(0));
    end
  endtask

  task automatic run(input int ncyc);
    int w;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 0) rst = 1'b0;
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1'b1;
          ids[i]  = 8'($urandom);
        end
      ia.req_vld = pend;
      for (int i = 0; i < N; i++) ia.req_ray_id[8*i +: 8] = ids[i];
      #1;
      while (q.size() > 0 && q[0].g + 2 + PL < c) void'(q.pop_front());
      if (q.size() > 0 && q[0].g + 2 + PL == c) begin
        chk("rsp_vld", 128'(ia.rsp_vld), 128'(1 << q[0].idx));
        chk("rsp_ray_id", 128'(ia.rsp_ray_id), 128'(q[0].id));
        chk("rsp_dir", 128'(ia.rsp_dir), 128'({q[0].r2, q[0].r1, 56'h0, q[0].id}));
      end else
        chk("rsp_idle", 128'(ia.rsp_vld), 128'(0));
      chk("op_vld", 128'(ia.sd_op_vld), 128'(op_e));
      chk("r1", 128'(ia.sd_r1), 128'(r1e));
      chk("r2", 128'(ia.sd_r2), 128'(r2e));
      if (op_e)
        chk("op_range", 128'($signed(ia.sd_r1) >= -16'sd8191 && $signed(ia.sd_r1) <= 16'sd8191 &&
                             $signed(ia.sd_r2) >= -16'sd8191 && $signed(ia.sd_r2) <= 16'sd8191), 128'(1));
      chk("a_align_err", 128'(ia.align_err), 128'(0));
      w = -1;
      if (c >= PL + 1)
        for (int k = 0; k < N && w < 0; k++) begin
          int j;
          j = (rr + k) % N;
          if (pend[j] && outst(j) < 8) w = j;
        end
      chk("req_rdy", 128'(ia.req_rdy), 128'(w >= 0 ? 1 << w : 0));
      op_e = w >= 0;
      if (w >= 0) begin
        r1e = opm(lf, 0);
        r2e = opm(lf, 16);
        q.push_back('{c, w, ids[w], r1e, r2e});
        lf      = lnext(lf);
        rr      = (w + 1) % N;
        pend[w] = 1'b0;
      end
      if (c <= 2 * PL + 4)
        chk("b_rdy", 128'(ib.req_rdy),
            128'(((c >= PL + 1 && c <= PL + 3) || c == 2 * PL + 4) ? 4'b0100 : 4'b0000));
      if (c == PL + 2) begin
        chk("b_r1_forced", 128'(ib.sd_r1), 128'(16'hE001));
        chk("b_r2_forced", 128'(ib.sd_r2), 128'(16'h0000));
      end
      chk("c_align_err", 128'(ic.align_err), 128'(c >= 2 * PL + 3));
    end
  endtask

  initial begin
    pend = '1;
    for (int i = 0; i < N; i++) ids[i] = 8'($urandom);
    ia.req_vld    = pend;
    ia.req_ray_id = '0;
    ib.req_vld    = 4'b0100;
    ib.req_ray_id = '0;
    ic.req_vld    = 4'b0001;
    ic.req_ray_id = '0;
    do_reset(3);
    run(200);
    do_reset(3);
    run(200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
